triangle_traverser: RTL and testbench

TRIANGLE_TRAVERSER -- requirements
Module: triangle_traverser

---
 rtl/triangle_traverser.sv | 171 +++++++++++++++++
 tb/tb_triangle_traverser.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/triangle_traverser.sv
// Triangle bounding-box traverser: converts a triangle setup record into a
// row-major stream of candidate pixels covering its screen-clamped bounding box.
package triangle_traverser_pkg;

  typedef struct packed {
    logic [18:0] v0x;
    logic [18:0] v0y;
    logic [18:0] e0x;
    logic [18:0] e0y;
    logic [18:0] e1x;
    logic [18:0] e1y;
  } triangle_state_t;

  typedef struct packed {
    logic [15:0]     x;
    logic [15:0]     y;
    triangle_state_t triangle;
  } pixel_state_t;

endpackage

module triangle_traverser
  import triangle_traverser_pkg::*;
#(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240
) (
  input  logic            clk,
  input  logic            rst,
  input  triangle_state_t in_triangle,
  input  logic            in_valid,
  output logic            in_ready,
  output pixel_state_t    out_pixel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy
);

  localparam int unsigned CW = 20;
  localparam int unsigned PW = 16;
  localparam logic signed [CW-1:0] XLIM = CW'(WIDTH - 1);
  localparam logic signed [CW-1:0] YLIM = CW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, EMIT} state_t;

  state_t          state;
  triangle_state_t tri_q;
  logic [PW-1:0]   x, y, xmin_q, xmax_q, ymax_q;
  logic [PW-1:0]   x_nx, y_nx;

  function automatic logic signed [CW-1:0] sext(input logic [18:0] v);
    return $signed({v[18], v});
  endfunction

  function automatic logic signed [CW-1:0] min3(input logic signed [CW-1:0] a,
                                                input logic signed [CW-1:0] b,
                                                input logic signed [CW-1:0] c);
    logic signed [CW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [CW-1:0] max3(input logic signed [CW-1:0] a,
                                                input logic signed [CW-1:0] b,
                                                input logic signed [CW-1:0] c);
    logic signed [CW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Vertices in full Q16.3 precision; 20 bits cannot overflow from 19-bit sums
  logic signed [CW-1:0] v0x, v0y, v1x, v1y, v2x, v2y;
  assign v0x = sext(tri_q.v0x);
  assign v0y = sext(tri_q.v0y);
  assign v1x = v0x + sext(tri_q.e0x);
  assign v1y = v0y + sext(tri_q.e0y);
  assign v2x = v0x + sext(tri_q.e1x);
  assign v2y = v0y + sext(tri_q.e1y);

  // Pixel bounds: arithmetic shift floors the fractional part, then clamp to screen
  logic signed [CW-1:0] xmin_r, xmax_r, ymin_r, ymax_r;
  logic signed [CW-1:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic                 box_empty;
  assign xmin_r    = min3(v0x, v1x, v2x) >>> 3;
  assign xmax_r    = max3(v0x, v1x, v2x) >>> 3;
  assign ymin_r    = min3(v0y, v1y, v2y) >>> 3;
  assign ymax_r    = max3(v0y, v1y, v2y) >>> 3;
  assign xmin_c    = (xmin_r < 0) ? '0 : xmin_r;
  assign ymin_c    = (ymin_r < 0) ? '0 : ymin_r;
  assign xmax_c    = (xmax_r > XLIM) ? XLIM : xmax_r;
  assign ymax_c    = (ymax_r > YLIM) ? YLIM : ymax_r;
  assign box_empty = (xmin_c > xmax_c) || (ymin_c > ymax_c);

  always_comb begin
    x_nx = xmin_q;
    y_nx = y + PW'(1);
    if (x < xmax_q) begin
      x_nx = x + PW'(1);
      y_nx = y;
    end
  end

  assign out_pixel = '{x: x, y: y, triangle: tri_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tri_q     <= '0;
      x         <= '0;
      y         <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymax_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tri_q    <= in_triangle;
            state    <= SETUP;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (box_empty) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            x         <= PW'(xmin_c);
            y         <= PW'(ymin_c);
            xmin_q    <= PW'(xmin_c);
            xmax_q    <= PW'(xmax_c);
            ymax_q    <= PW'(ymax_c);
            out_valid <= 1'b1;
            out_last  <= (xmin_c == xmax_c) && (ymin_c == ymax_c);
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              x        <= x_nx;
              y        <= y_nx;
              out_last <= (x_nx == xmax_q) && (y_nx == ymax_q);
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_traverser.sv
// Bench for triangle_traverser: directed and random triangles checked against
// a bounding-box pixel-order model under random downstream backpressure.
module tb_triangle_traverser;
  import triangle_traverser_pkg::*;

  localparam int W = 320;
  localparam int H = 240;

  logic            clk = 1'b0;
  logic            rst;
  triangle_state_t in_triangle;
  logic            in_valid;
  logic            in_ready;
  pixel_state_t    out_pixel;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  triangle_traverser #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_triangle(in_triangle),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_pixel  (out_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int floor8(input int a);
    return (a < 0) ? -((-a + 7) / 8) : a / 8;
  endfunction

  function automatic int mn(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic int mx(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic triangle_state_t mk(input int v0x, input int v0y, input int e0x,
                                         input int e0y, input int e1x, input int e1y);
    triangle_state_t t;
    t.v0x = 19'(v0x); t.v0y = 19'(v0y);
    t.e0x = 19'(e0x); t.e0y = 19'(e0y);
    t.e1x = 19'(e1x); t.e1y = 19'(e1y);
    return t;
  endfunction

  // Present one triangle and check the whole pixel stream it should produce
  task automatic run_tri(input int v0x, input int v0y, input int e0x, input int e0y,
                         input int e1x, input int e1y, input int ready_pct, input int stall_first);
    int xmin, xmax, ymin, ymax, w, total, idx, cyc, ex, ey;
    logic hs;
    triangle_state_t t;
    t    = mk(v0x, v0y, e0x, e0y, e1x, e1y);
    xmin = floor8(mn(v0x, v0x + e0x, v0x + e1x));
    xmax = floor8(mx(v0x, v0x + e0x, v0x + e1x));
    ymin = floor8(mn(v0y, v0y + e0y, v0y + e1y));
    ymax = floor8(mx(v0y, v0y + e0y, v0y + e1y));
    if (xmin < 0) xmin = 0;
    if (ymin < 0) ymin = 0;
    if (xmax > W - 1) xmax = W - 1;
    if (ymax > H - 1) ymax = H - 1;

    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready_before", in_ready, 1'b1);
    in_triangle = t;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("setup_busy", busy, 1'b1);
    check("setup_in_ready", in_ready, 1'b0);
    check("setup_valid", out_valid, 1'b0);
    @(negedge clk);

    if (xmin > xmax || ymin > ymax) begin
      check("empty_valid", out_valid, 1'b0);
      check("empty_busy", busy, 1'b0);
      check("empty_in_ready", in_ready, 1'b1);
      return;
    end

    check("first_valid", out_valid, 1'b1);
    w     = xmax - xmin + 1;
    total = w * (ymax - ymin + 1);
    idx   = 0;
    cyc   = 0;
    while (idx < total && cyc < 20000) begin
      if (!out_valid) begin
        check("valid_dropped", out_valid, 1'b1);
        break;
      end
      ex = xmin + idx % w;
      ey = ymin + idx / w;
      check("px_x", out_pixel.x, ex);
      check("px_y", out_pixel.y, ey);
      check("px_last", out_last, idx == total - 1);
      check("px_tri", out_pixel.triangle, t);
      hs = (cyc < stall_first) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
      out_ready = hs;
      @(negedge clk);
      cyc++;
      if (hs) idx++;
    end
    out_ready = 1'b0;
    if (cyc >= 20000) check("stream_timeout", 1'b0, 1'b1);
    check("done_valid", out_valid, 1'b0);
    check("done_busy", busy, 1'b0);
    check("done_in_ready", in_ready, 1'b1);
  endtask

  task automatic reset_mid();
    in_triangle = mk(0, 0, 24, 0, 0, 16);
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rm_first_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("rm_px_x", out_pixel.x, i % 4);
      check("rm_px_y", out_pixel.y, i / 4);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rm_valid", out_valid, 1'b0);
    check("rm_busy", busy, 1'b0);
    check("rm_in_ready", in_ready, 1'b1);
    check("rm_px_cleared", out_pixel, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rm_quiet", out_valid, 1'b0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_triangle = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pixel", out_pixel, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);

    run_tri(0, 0, 24, 0, 0, 16, 100, 0);
    run_tri(-80, -80, 160, 0, 0, 160, 100, 0);
    run_tri(3200, 0, 8, 0, 0, 8, 100, 0);
    run_tri(0, 0, 24, 0, 0, 16, 100, 5);
    run_tri(0, 0, 24, 0, 0, 16, 100, 0);
    run_tri(8, 8, 8, 0, 0, 8, 100, 0);
    reset_mid();
    run_tri(0, 0, 24, 0, 0, 16, 100, 0);
    run_tri(2540, 1890, 40, -8, 16, 30, 70, 0);
    run_tri(-30, 1000, -20, 5, 7, -9, 50, 2);

    for (int n = 0; n < 25; n++) begin
      run_tri(int'($urandom_range(2800)) - 200, int'($urandom_range(2100)) - 150,
              int'($urandom_range(128)) - 64, int'($urandom_range(128)) - 64,
              int'($urandom_range(128)) - 64, int'($urandom_range(128)) - 64,
              int'($urandom_range(30, 100)), int'($urandom_range(3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
